noc_port_fifo: RTL and testbench

Per-CPU ingress buffer between a CPU's `data_cpu_to_noc*` valid/ready stream and the matching NoC input port; one instance per `cpu_idx`. It decouples CPU issue from NoC back-pressure by holding up to `DEPTH` 64-bit words in order. Both sides use the codebase's rdy/vld handshake. Optional statistics counters support performance comparison between native and multisim runs.

---
 rtl/noc_pkg.sv | 9 +
 rtl/noc_port_fifo_mem.sv | 28 ++
 rtl/noc_port_fifo.sv | 89 ++++++++
 tb/tb_noc_port_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions used by the CPU, NoC and multisim server wrappers.
package noc_pkg;

    localparam int DATA_W         = 64;
    localparam int NOC_FIFO_DEPTH = 8;

    typedef logic [DATA_W-1:0] noc_data_t;

endpackage

// File: rtl/noc_port_fifo_mem.sv
// Storage array for noc_port_fifo.
// Registered write port, asynchronous read port, and no reset.
module noc_port_fifo_mem
    import noc_pkg::*;
#(
    parameter int DEPTH = NOC_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  noc_data_t     wdata,
    input  logic [AW-1:0] raddr,
    output noc_data_t     rdata
);

    noc_data_t mem [DEPTH];

    // Write the accepted word into its slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/noc_port_fifo.sv
// Per-CPU ingress FIFO between the CPU data stream and a NoC input port.
// The flags are derived only from the wr/rd pointer pair.
// Optional statistics are enabled with NOC_PORT_FIFO_STATS_EN.
// They consist of xfer_count (number of pops) and stall_count (cycles where in_vld is held off).
module noc_port_fifo
    import noc_pkg::*;
#(
    parameter int  DEPTH = NOC_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  noc_data_t     in_data,
    output logic          in_rdy,
    output logic          out_vld,
    output noc_data_t     out_data,
    input  logic          out_rdy,
    output logic [AW:0]   level
`ifdef NOC_PORT_FIFO_STATS_EN
    ,
    output logic [31:0]   xfer_count,
    output logic [31:0]   stall_count
`endif
);

    // The MSB of each pointer is the wrap bit.
    // Equal low bits therefore mean either empty or full, and the wrap bit tells them apart.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign in_rdy  = !full;
    assign out_vld = !empty;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;
    assign level   = wr_ptr - rd_ptr;

    noc_port_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (out_data)
    );

    // Advance the pointers on accepted handshakes.
    // Reset drops all stored words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

`ifdef NOC_PORT_FIFO_STATS_EN
    // Count pops and back-pressured cycles; both counters wrap modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_count  <= '0;
            stall_count <= '0;
        end else begin
            if (pop) begin
                xfer_count <= xfer_count + 32'd1;
            end
            if (in_vld && !in_rdy) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_port_fifo.sv
// Randomized and directed bench for noc_port_fifo.
// The reference model is a bounded queue with a capacity of DEPTH.
module tb_noc_port_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic [63:0]   in_data;
    logic          in_rdy;
    logic          out_vld;
    logic [63:0]   out_data;
    logic          out_rdy;
    logic [AW:0]   level;
`ifdef NOC_PORT_FIFO_STATS_EN
    logic [31:0]   xfer_count;
    logic [31:0]   stall_count;
`endif

    noc_port_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .level    (level)
`ifdef NOC_PORT_FIFO_STATS_EN
        ,
        .xfer_count  (xfer_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q[$];
    int unsigned m_xfer  = 0;
    int unsigned m_stall = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, update the model at the edge, then compare the outputs.
    task automatic step(input logic v, input logic [63:0] d, input logic r, input logic rn);
        bit do_push;
        bit do_pop;
        bit do_stall;
        @(negedge clk);
        rst_n   = rn;
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        do_push  = v && (q.size() < DEPTH);
        do_pop   = r && (q.size() > 0);
        do_stall = v && (q.size() == DEPTH);
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_xfer  = 0;
            m_stall = 0;
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                m_xfer++;
            end
            if (do_push) begin
                q.push_back(d);
            end
            if (do_stall) begin
                m_stall++;
            end
        end
        #1;
        check("in_rdy", 64'(in_rdy), 64'(q.size() < DEPTH));
        check("out_vld", 64'(out_vld), 64'(q.size() > 0));
        check("level", 64'(level), 64'(q.size()));
        if (q.size() > 0) begin
            check("out_data", out_data, q[0]);
        end
`ifdef NOC_PORT_FIFO_STATS_EN
        check("xfer_count", 64'(xfer_count), 64'(m_xfer));
        check("stall_count", 64'(stall_count), 64'(m_stall));
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;

        // Reset followed by five idle cycles.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1);
        end
        check("idle_level", 64'(level), 64'd0);
        check("idle_in_rdy", 64'(in_rdy), 64'd1);

        // Three back-to-back pushes while the NoC side is stalled, then drain.
        step(1, 64'h1111_1111_1111_1111, 0, 1);
        check("lvl1", 64'(level), 64'd1);
        step(1, 64'h2222_2222_2222_2222, 0, 1);
        check("lvl2", 64'(level), 64'd2);
        step(1, 64'h3333_3333_3333_3333, 0, 1);
        check("lvl3", 64'(level), 64'd3);
        check("head0", out_data, 64'h1111_1111_1111_1111);
        step(0, 0, 1, 1);
        check("head1", out_data, 64'h2222_2222_2222_2222);
        step(0, 0, 1, 1);
        check("head2", out_data, 64'h3333_3333_3333_3333);
        step(0, 0, 1, 1);
        check("drained", 64'(level), 64'd0);

        // Fill to capacity, hold a 9th word, then free one slot.
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 64'(100 + i), 0, 1);
        end
        check("full_in_rdy", 64'(in_rdy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 64'd999, 0, 1);
        end
        step(1, 64'd999, 1, 1);
        check("after_pop_level", 64'(level), 64'd7);
        step(1, 64'd999, 0, 1);
        check("ninth_level", 64'(level), 64'd8);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 1);
        end

        // Streaming twenty words, one per cycle, across the pointer wrap.
        step(1, 64'd0, 1, 1);
        for (int i = 1; i < 20; i++) begin
            step(1, 64'(i), 1, 1);
            check("stream_level", 64'(level), 64'd1);
            check("stream_head", out_data, 64'(i));
        end
        step(0, 0, 1, 1);

        // Randomized traffic at 50% on both sides.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 1);
        end

        // Reset while holding five words; those words must never reappear.
        for (int i = 0; i < 5; i++) begin
            step(1, 64'hDEAD_0000 + 64'(i), 0, 1);
        end
        check("pre_rst_level", 64'(level), 64'd5);
        step(0, 0, 0, 0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_out_vld", 64'(out_vld), 64'd0);
        step(1, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1);
        check("post_rst_head", out_data, 64'hAAAA_AAAA_AAAA_AAAA);
        step(0, 0, 1, 1);
        check("post_rst_empty", 64'(out_vld), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
